// File: rtl/adder_tree.sv
// adder_tree: pipelined binary reduction tree that sums NUM operands of
// BITS bits. There are LAT = clog2(NUM) register stages, with one addition
// level per stage. The full-precision sum is converted to OUT_BITS at the
// last stage, by wrapping or by saturating.
//
// Parameters:
//   BITS     - operand width
//   NUM      - operand count (2..64, need not be a power of two)
//   OUT_BITS - result width (1..BITS+clog2(NUM))
//   SIGNED   - 1: operands and result are two's complement
//   SAT      - 1: clamp the result when it is out of range, 0: wrap
//
// Ports:
//   clk       - clock; all state updates on the rising edge
//   rst       - asynchronous active-high reset
//   valid_in  - an operand set is present on i
//   ready_out - the block accepts an operand set this cycle
//   i         - packed operands; operand k is at i[k*BITS +: BITS]
//   o         - converted sum
//   valid_out - o is valid
//   ready_in  - downstream accepts o
//   ovf       - sticky flag: an out-of-range sum was handed off
//   ovf_clr   - synchronous clear of ovf; a set in the same cycle wins
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid (and its data) until the transfer
// happens. The pipeline advances only when en = !valid_out | ready_in, and
// ready_out equals en, so the block never drops a result it is presenting.
module adder_tree #(
  parameter int BITS     = 8,
  parameter int NUM      = 8,
  parameter int OUT_BITS = BITS,
  parameter int SIGNED   = 0,
  parameter int SAT      = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  output logic                     ready_out,
  input  logic [NUM*BITS-1:0]      i,
  output logic [OUT_BITS-1:0]      o,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int LAT = $clog2(NUM);
  localparam int FW  = BITS + LAT;

  // Every node is held at the full width FW. A node at level l only ever
  // carries a value that fits in BITS+l bits, so the extra high bits are
  // pure sign or zero extension and synthesis trims them. No level can
  // overflow.
  logic [FW-1:0] lvl_in [LAT][2*NUM];
  logic [FW-1:0] nxt    [LAT][NUM];
  logic [FW-1:0] dat    [LAT][NUM];
  logic [LAT-1:0] vld;
  logic          en;
  logic [FW-1:0] s_full;
  logic          ovr;

  function automatic logic [FW-1:0] ext(input logic [BITS-1:0] x);
    if (SIGNED != 0) return {{LAT{x[BITS-1]}}, x};
    else             return {{LAT{1'b0}}, x};
  endfunction

  // The input vector of each level is padded with zero nodes up to 2*NUM
  // entries. A node past the live count of a level is always zero, so an
  // odd leftover operand is added to zero. It passes through unchanged
  // without any special case.
  always_comb begin
    for (int l = 0; l < LAT; l++)
      for (int k = 0; k < 2*NUM; k++)
        lvl_in[l][k] = '0;
    for (int k = 0; k < NUM; k++)
      lvl_in[0][k] = ext(i[k*BITS +: BITS]);
    for (int l = 1; l < LAT; l++)
      for (int k = 0; k < NUM; k++)
        lvl_in[l][k] = dat[l-1][k];
    for (int l = 0; l < LAT; l++)
      for (int k = 0; k < NUM; k++)
        nxt[l][k] = lvl_in[l][2*k] + lvl_in[l][2*k+1];
  end

  assign valid_out = vld[LAT-1];
  assign en        = !valid_out | ready_in;
  assign ready_out = en;

  // Data is reset too, so o never shows X. Data in an invalid stage still
  // moves, but nothing downstream looks at it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int l = 0; l < LAT; l++)
        for (int k = 0; k < NUM; k++)
          dat[l][k] <= '0;
    end else if (en) begin
      vld[0] <= valid_in;
      for (int l = 1; l < LAT; l++)
        vld[l] <= vld[l-1];
      for (int l = 0; l < LAT; l++)
        for (int k = 0; k < NUM; k++)
          dat[l][k] <= nxt[l][k];
    end
  end

  assign s_full = dat[LAT-1][0];

  // Output conversion of the full sum s_full.
  generate
    if (OUT_BITS == FW) begin : g_full
      assign o   = s_full;
      assign ovr = 1'b0;
    end else if (SIGNED != 0) begin : g_signed
      localparam logic [OUT_BITS-1:0] MINV = OUT_BITS'(1) << (OUT_BITS - 1);
      localparam logic [OUT_BITS-1:0] MAXV = MINV - OUT_BITS'(1);
      // The sum fits only when every bit from the OUT_BITS sign position up
      // is a copy of the sign.
      logic [FW-OUT_BITS:0] top;
      assign top = s_full[FW-1:OUT_BITS-1];
      assign ovr = !((&top) | ~(|top));
      assign o   = (ovr && SAT != 0) ? (s_full[FW-1] ? MINV : MAXV)
                                     : s_full[OUT_BITS-1:0];
    end else begin : g_unsigned
      assign ovr = |s_full[FW-1:OUT_BITS];
      assign o   = (ovr && SAT != 0) ? '1 : s_full[OUT_BITS-1:0];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               ovf <= 1'b0;
    else if (valid_out && ready_in && ovr) ovf <= 1'b1;
    else if (ovf_clr)                      ovf <= 1'b0;
  end

endmodule

// File: tb/tb_adder_tree.sv
module tb_adder_tree;

  localparam int LAT = 3;
  localparam int ND  = 5;
  localparam int P_BITS [ND] = '{8, 8, 8, 8, 6};
  localparam int P_NUM  [ND] = '{5, 8, 8, 8, 7};
  localparam int P_OB   [ND] = '{11, 8, 8, 8, 7};
  localparam int P_SGN  [ND] = '{0, 0, 0, 1, 1};
  localparam int P_SAT  [ND] = '{0, 0, 1, 1, 0};

  logic clk, rst, valid_in, ready_in, ovf_clr;
  logic [39:0] i0;
  logic [63:0] i8;
  logic [41:0] i6;
  logic [10:0] o0;
  logic [7:0]  o1, o2, o3;
  logic [6:0]  o4;
  logic [ND-1:0] vo, ro, fo;
  logic [15:0] obs_o [ND];

  adder_tree #(.BITS(8), .NUM(5), .OUT_BITS(11), .SIGNED(0), .SAT(0)) u0 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ro[0]), .i(i0),
    .o(o0), .valid_out(vo[0]), .ready_in(ready_in), .ovf(fo[0]), .ovf_clr(ovf_clr));
  adder_tree #(.BITS(8), .NUM(8), .OUT_BITS(8), .SIGNED(0), .SAT(0)) u1 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ro[1]), .i(i8),
    .o(o1), .valid_out(vo[1]), .ready_in(ready_in), .ovf(fo[1]), .ovf_clr(ovf_clr));
  adder_tree #(.BITS(8), .NUM(8), .OUT_BITS(8), .SIGNED(0), .SAT(1)) u2 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ro[2]), .i(i8),
    .o(o2), .valid_out(vo[2]), .ready_in(ready_in), .ovf(fo[2]), .ovf_clr(ovf_clr));
  adder_tree #(.BITS(8), .NUM(8), .OUT_BITS(8), .SIGNED(1), .SAT(1)) u3 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ro[3]), .i(i8),
    .o(o3), .valid_out(vo[3]), .ready_in(ready_in), .ovf(fo[3]), .ovf_clr(ovf_clr));
  adder_tree #(.BITS(6), .NUM(7), .OUT_BITS(7), .SIGNED(1), .SAT(0)) u4 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ro[4]), .i(i6),
    .o(o4), .valid_out(vo[4]), .ready_in(ready_in), .ovf(fo[4]), .ovf_clr(ovf_clr));

  always_comb begin
    obs_o[0] = 16'(o0);
    obs_o[1] = 16'(o1);
    obs_o[2] = 16'(o2);
    obs_o[3] = 16'(o3);
    obs_o[4] = 16'(o4);
  end

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state: per design {ovr, o}; acceptance cycle and stall count
  logic [16:0] exp_q [ND][$];
  int          acc_q [$];
  int          st_q  [$];
  int          total, bad, cyc, stall_cnt;
  logic        ovf_m [ND];
  logic        hold_prev;
  logic [15:0] o_prev [ND];

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  // Reference: plain integer sum, then range check and wrap/clamp.
  function automatic logic [16:0] model(input int d, input logic [63:0] ops);
    longint s, v, m, lo, hi, r;
    int b, ob;
    logic ovr;
    b  = P_BITS[d];
    ob = P_OB[d];
    m  = (longint'(1) << b) - 1;
    s  = 0;
    for (int k = 0; k < P_NUM[d]; k++) begin
      v = longint'(ops >> (k*b)) & m;
      if (P_SGN[d] != 0 && v > (m >> 1)) v = v - (m + 1);
      s = s + v;
    end
    if (P_SGN[d] != 0) begin
      lo = -(longint'(1) << (ob - 1));
      hi = (longint'(1) << (ob - 1)) - 1;
    end else begin
      lo = 0;
      hi = (longint'(1) << ob) - 1;
    end
    ovr = (s < lo) || (s > hi);
    r = (ovr && P_SAT[d] != 0) ? ((s > hi) ? hi : lo) : s;
    return {ovr, 16'(r & ((longint'(1) << ob) - 1))};
  endfunction

  function automatic logic [63:0] ops_of(input int d);
    if (d == 0)      return 64'(i0);
    else if (d == 4) return 64'(i6);
    else             return i8;
  endfunction

  // One clock cycle: checks at mid-cycle, then advance to just after the edge.
  task automatic tick(output bit acc);
    bit hs, stall;
    logic ovr_hs [ND];
    logic [16:0] e;
    #4;
    hs = 1'b0;
    for (int d = 0; d < ND; d++) begin
      ovr_hs[d] = 1'b0;
      chk("ovf", d, fo[d], ovf_m[d]);
      chk("ready", d, ro[d], !vo[d] | ready_in);
      if (hold_prev) chk("hold", d, obs_o[d], o_prev[d]);
    end
    if (acc_q.size() == 0) begin
      for (int d = 0; d < ND; d++) chk("spurious", d, vo[d], 0);
    end else if (vo[0]) begin
      for (int d = 0; d < ND; d++) begin
        e = exp_q[d][0];
        chk("valid", d, vo[d], 1);
        chk("sum", d, obs_o[d], e[15:0]);
        ovr_hs[d] = e[16];
      end
      if (st_q[0] == stall_cnt) chk("latency", 0, cyc - acc_q[0], LAT);
      if (ready_in) begin
        hs = 1'b1;
        for (int d = 0; d < ND; d++) void'(exp_q[d].pop_front());
        void'(acc_q.pop_front());
        void'(st_q.pop_front());
      end
    end else if (st_q[0] == stall_cnt && cyc == acc_q[0] + LAT) begin
      chk("valid_due", 0, vo[0], 1);
    end
    acc = valid_in && (!vo[0] || ready_in);
    if (acc) begin
      for (int d = 0; d < ND; d++) exp_q[d].push_back(model(d, ops_of(d)));
      acc_q.push_back(cyc);
      st_q.push_back(stall_cnt);
    end
    stall = vo[0] && !ready_in;
    if (stall) stall_cnt++;
    hold_prev = stall;
    for (int d = 0; d < ND; d++) o_prev[d] = obs_o[d];
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < ND; d++)
      ovf_m[d] = (hs && ovr_hs[d]) || (ovf_m[d] && !ovf_clr);
  endtask

  // driver tasks
  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) begin
      chk("rst_valid", d, vo[d], 0);
      chk("rst_ovf", d, fo[d], 0);
      chk("rst_o", d, obs_o[d], 0);
      exp_q[d].delete();
      ovf_m[d] = 1'b0;
    end
    acc_q.delete();
    st_q.delete();
    hold_prev = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int d = 0; d < ND; d++) chk("ready_first", d, ro[d], 1);
  endtask

  task automatic rnd_data();
    i0 = {$urandom(), $urandom()};
    i8 = {$urandom(), $urandom()};
    i6 = {$urandom(), $urandom()};
  endtask

  task automatic beat();
    bit acc;
    valid_in = 1'b1;
    tick(acc);
    valid_in = 1'b0;
    if (!acc) chk("accept", 0, 32'(acc), 1);
  endtask

  task automatic idle(input int n);
    bit acc;
    valid_in = 1'b0;
    for (int c = 0; c < n; c++) tick(acc);
  endtask

  task automatic drain();
    bit acc;
    valid_in = 1'b0;
    ready_in = 1'b1;
    for (int c = 0; c < 40 && acc_q.size() > 0; c++) tick(acc);
    chk("drained", 0, acc_q.size(), 0);
    tick(acc);
  endtask

  initial begin
    bit acc;
    int sent;
    total = 0; bad = 0; cyc = 0; stall_cnt = 0;
    valid_in = 1'b0; ready_in = 1'b0; ovf_clr = 1'b0;
    i0 = '0; i8 = '0; i6 = '0;
    do_reset();

    // first cycle after reset with downstream not ready
    idle(1);

    // operands 1..5, single beat, then back-to-back random beats
    ready_in = 1'b1;
    i0 = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    i8 = {$urandom(), $urandom()};
    i6 = {$urandom(), $urandom()};
    beat();
    idle(4);
    for (int b = 0; b < 6; b++) begin
      rnd_data();
      beat();
    end
    idle(4);

    // all 0xFF, then all 0x80: wrap, unsigned clamp, signed clamp
    i8 = {8{8'hFF}};
    beat();
    i8 = {8{8'h80}};
    beat();
    idle(4);
    chk("ovf_after_ff", 1, fo[1], 1);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    chk("ovf_cleared", 1, fo[1], 0);
    idle(1);

    // 10 beats with downstream stalled for 5 cycles mid-stream
    sent = 0;
    rnd_data();
    for (int c = 0; c < 40 && sent < 10; c++) begin
      ready_in = !(c >= 3 && c < 8);
      valid_in = 1'b1;
      tick(acc);
      if (acc) begin
        sent++;
        rnd_data();
      end
    end
    chk("sent", 0, sent, 10);
    drain();

    // overflowing handshake coincides with ovf_clr: set wins
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    i8 = {8{8'hFF}};
    beat();
    idle(2);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    chk("set_wins", 1, fo[1], 1);
    chk("set_wins", 2, fo[2], 1);
    idle(1);

    // reset with beats in flight
    rnd_data();
    beat();
    rnd_data();
    beat();
    idle(1);
    do_reset();
    idle(6);
    rnd_data();
    beat();
    idle(4);

    // random traffic and backpressure
    for (int c = 0; c < 60; c++) begin
      rnd_data();
      valid_in = 1'($urandom_range(0, 1));
      ready_in = ($urandom_range(0, 3) != 0);
      ovf_clr  = ($urandom_range(0, 7) == 0);
      tick(acc);
    end
    ovf_clr = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
